// File: rtl/q_sys_master_0_st_arbiter.sv
// ============================================================================
//  Module   : q_sys_master_0_st_arbiter
//  Purpose  : Packet-aware round-robin arbiter merging NUM_IN 8-bit Avalon-ST
//             streams into one registered, backpressured, channel-tagged stream.
//  Options  : ST_ARB_TIMEOUT_EN - revoke a grant after TIMEOUT idle cycles
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_sys_master_0_st_arbiter #(
  parameter int NUM_IN  = 2,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_IN-1:0]     in_valid,
  input  logic [8*NUM_IN-1:0]   in_data,
  input  logic [NUM_IN-1:0]     in_sop,
  input  logic [NUM_IN-1:0]     in_eop,
  output logic [NUM_IN-1:0]     in_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [CH_W-1:0]       out_channel,
  input  logic                  out_ready,
  output logic                  arb_timeout
);

  localparam int         c_PAD    = 1 << CH_W;
  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_LOCK = 1'b1;

  logic [0:0]         r_state;
  logic [CH_W-1:0]    r_grant;
  logic [CH_W-1:0]    r_last;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_out_sop;
  logic               r_out_eop;
  logic [CH_W-1:0]    r_out_channel;

  logic [c_PAD-1:0]   w_valid_pad;
  logic [c_PAD-1:0]   w_sop_pad;
  logic [c_PAD-1:0]   w_eop_pad;
  logic [8*c_PAD-1:0] w_data_pad;
  logic               w_g_valid;
  logic [7:0]         w_g_data;
  logic               w_g_sop;
  logic               w_g_eop;
  logic               w_lock;
  logic               w_space;
  logic               w_accept;
  logic               w_release;
  logic               w_tout;
  logic               w_found;
  logic [CH_W-1:0]    w_pick;
  logic [CH_W-1:0]    w_idx;

  // Widen the source buses to 2**CH_W so r_grant indexes them exactly.
  always_comb begin
    w_valid_pad = '0;
    w_sop_pad   = '0;
    w_eop_pad   = '0;
    w_data_pad  = '0;
    w_valid_pad[NUM_IN-1:0]   = in_valid;
    w_sop_pad[NUM_IN-1:0]     = in_sop;
    w_eop_pad[NUM_IN-1:0]     = in_eop;
    w_data_pad[8*NUM_IN-1:0]  = in_data;
  end

  assign w_g_valid = w_valid_pad[r_grant];
  assign w_g_sop   = w_sop_pad[r_grant];
  assign w_g_eop   = w_eop_pad[r_grant];
  assign w_g_data  = w_data_pad[{r_grant, 3'b000} +: 8];

  assign w_lock    = (r_state == c_S_LOCK);
  assign w_space   = ~r_out_valid | out_ready;
  assign w_accept  = w_lock & w_space & w_g_valid;
  assign w_release = w_accept & w_g_eop;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = w_lock & w_space & (r_grant == CH_W'(gi));
    end
  endgenerate

  // Round-robin search starting at the source after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = r_last;
    for (int k = 0; k < NUM_IN; k++) begin
      w_idx = (w_idx == CH_W'(NUM_IN - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && w_valid_pad[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

`ifdef ST_ARB_TIMEOUT_EN
  logic [7:0] r_idle;
  logic       r_tout;

  assign w_tout      = w_lock & ~w_g_valid & ((r_idle + 8'd1) == 8'(TIMEOUT));
  assign arb_timeout = r_tout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idle <= 8'd0;
      r_tout <= 1'b0;
    end else begin
      r_tout <= w_tout;
      if (!w_lock || w_accept || w_tout) begin
        r_idle <= 8'd0;
      end else if (!w_g_valid) begin
        r_idle <= r_idle + 8'd1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^8'(TIMEOUT);
  assign w_tout           = 1'b0;
  assign arb_timeout      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= c_S_IDLE;
      r_grant <= '0;
      r_last  <= CH_W'(NUM_IN - 1);
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= c_S_LOCK;
          end
        end
        c_S_LOCK: begin
          if (w_release || w_tout) begin
            r_last  <= r_grant;
            r_state <= c_S_IDLE;
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= 8'd0;
      r_out_sop     <= 1'b0;
      r_out_eop     <= 1'b0;
      r_out_channel <= '0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= w_g_data;
      r_out_sop     <= w_g_sop;
      r_out_eop     <= w_g_eop;
      r_out_channel <= r_grant;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_sop     = r_out_sop;
  assign out_eop     = r_out_eop;
  assign out_channel = r_out_channel;

endmodule

`default_nettype wire
